// File: rtl/riscv_v_mul_seq.sv
// Vector multiply sequencer: walks an LMUL register group through the multiplier, one chunk per register.
// States: IDLE wait request | READ rf read | OPND operand capture | EXEC result capture | WB write-back.
// Define RISCV_V_MUL_SEQ_RESULT_REG_EN to register the multiplier result in EXEC (4 cycles/chunk, else 3).
module riscv_v_mul_seq #(
  parameter int DATA_WIDTH = 128,
  parameter int MAX_CHUNKS = 8,
  parameter int REG_IDX_W  = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_is_high_i,
  input  logic                  req_is_signed_i,
  input  logic [3:0]            req_osize_i,
  input  logic [3:0]            req_num_chunks_i,
  input  logic [REG_IDX_W-1:0]  req_vs1_i,
  input  logic [REG_IDX_W-1:0]  req_vs2_i,
  input  logic [REG_IDX_W-1:0]  req_vd_i,
  output logic                  rf_rd_en_o,
  output logic [REG_IDX_W-1:0]  rf_rd_idx_a_o,
  output logic [REG_IDX_W-1:0]  rf_rd_idx_b_o,
  input  logic [DATA_WIDTH-1:0] rf_rdata_a_i,
  input  logic [DATA_WIDTH-1:0] rf_rdata_b_i,
  output logic                  mul_is_mul_o,
  output logic                  mul_is_high_o,
  output logic                  mul_is_signed_o,
  output logic [3:0]            mul_osize_o,
  output logic [DATA_WIDTH-1:0] mul_srca_o,
  output logic [DATA_WIDTH-1:0] mul_srcb_o,
  input  logic [DATA_WIDTH-1:0] mul_result_i,
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output logic [REG_IDX_W-1:0]  wb_vd_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  output logic                  wb_last_o,
  output logic                  busy_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_OPND = 3'd2;
`ifdef RISCV_V_MUL_SEQ_RESULT_REG_EN
  localparam logic [2:0] S_EXEC = 3'd3;
`endif
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [3:0] MAX_N  = 4'(MAX_CHUNKS);

  logic [2:0]            state_q, state_d;
  logic [3:0]            k_q, k_d;
  logic [3:0]            num_q, num_d;
  logic [REG_IDX_W-1:0]  vs1_q, vs1_d, vs2_q, vs2_d, vd_q, vd_d;
  logic                  hi_q, hi_d, sg_q, sg_d;
  logic [3:0]            os_q, os_d;
  logic                  mul_is_mul_q, mul_is_mul_d;
  logic                  mul_hi_q, mul_hi_d, mul_sg_q, mul_sg_d;
  logic [3:0]            mul_os_q, mul_os_d;
  logic [DATA_WIDTH-1:0] srca_q, srca_d, srcb_q, srcb_d;
  logic [REG_IDX_W-1:0]  wb_vd_q, wb_vd_d;
  logic                  wb_last_q, wb_last_d;
`ifdef RISCV_V_MUL_SEQ_RESULT_REG_EN
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
`endif

  logic [REG_IDX_W-1:0] k_ext;
  logic                 k_is_last;
  logic [3:0]           req_num;

  assign k_ext     = REG_IDX_W'(k_q);
  assign k_is_last = (k_q == num_q - 4'd1);
  assign req_num   = (req_num_chunks_i == 4'd0) ? 4'd1 :
                     (req_num_chunks_i > MAX_N) ? MAX_N : req_num_chunks_i;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    num_d        = num_q;
    vs1_d        = vs1_q;
    vs2_d        = vs2_q;
    vd_d         = vd_q;
    hi_d         = hi_q;
    sg_d         = sg_q;
    os_d         = os_q;
    mul_is_mul_d = mul_is_mul_q;
    mul_hi_d     = mul_hi_q;
    mul_sg_d     = mul_sg_q;
    mul_os_d     = mul_os_q;
    srca_d       = srca_q;
    srcb_d       = srcb_q;
    wb_vd_d      = wb_vd_q;
    wb_last_d    = wb_last_q;
`ifdef RISCV_V_MUL_SEQ_RESULT_REG_EN
    wb_data_d    = wb_data_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          hi_d    = req_is_high_i;
          sg_d    = req_is_signed_i;
          os_d    = req_osize_i;
          vs1_d   = req_vs1_i;
          vs2_d   = req_vs2_i;
          vd_d    = req_vd_i;
          num_d   = req_num;
          k_d     = 4'd0;
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_OPND;
      S_OPND: begin
        srca_d       = rf_rdata_a_i;
        srcb_d       = rf_rdata_b_i;
        mul_is_mul_d = 1'b1;
        mul_hi_d     = hi_q;
        mul_sg_d     = sg_q;
        mul_os_d     = os_q;
`ifdef RISCV_V_MUL_SEQ_RESULT_REG_EN
        state_d      = S_EXEC;
`else
        wb_vd_d      = vd_q + k_ext;
        wb_last_d    = k_is_last;
        state_d      = S_WB;
`endif
      end
`ifdef RISCV_V_MUL_SEQ_RESULT_REG_EN
      S_EXEC: begin
        wb_data_d = mul_result_i;
        wb_vd_d   = vd_q + k_ext;
        wb_last_d = k_is_last;
        state_d   = S_WB;
      end
`endif
      S_WB: begin
        if (wb_ready_i) begin
          if (wb_last_q) begin
            mul_is_mul_d = 1'b0;
            state_d      = S_IDLE;
          end else begin
            k_d     = k_q + 4'd1;
            state_d = S_READ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Flush wins over everything, including an IDLE request or a WB handshake.
    if (flush_i) begin
      state_d      = S_IDLE;
      mul_is_mul_d = 1'b0;
      k_d          = 4'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      num_q        <= '0;
      vs1_q        <= '0;
      vs2_q        <= '0;
      vd_q         <= '0;
      hi_q         <= 1'b0;
      sg_q         <= 1'b0;
      os_q         <= '0;
      mul_is_mul_q <= 1'b0;
      mul_hi_q     <= 1'b0;
      mul_sg_q     <= 1'b0;
      mul_os_q     <= '0;
      srca_q       <= '0;
      srcb_q       <= '0;
      wb_vd_q      <= '0;
      wb_last_q    <= 1'b0;
`ifdef RISCV_V_MUL_SEQ_RESULT_REG_EN
      wb_data_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      num_q        <= num_d;
      vs1_q        <= vs1_d;
      vs2_q        <= vs2_d;
      vd_q         <= vd_d;
      hi_q         <= hi_d;
      sg_q         <= sg_d;
      os_q         <= os_d;
      mul_is_mul_q <= mul_is_mul_d;
      mul_hi_q     <= mul_hi_d;
      mul_sg_q     <= mul_sg_d;
      mul_os_q     <= mul_os_d;
      srca_q       <= srca_d;
      srcb_q       <= srcb_d;
      wb_vd_q      <= wb_vd_d;
      wb_last_q    <= wb_last_d;
`ifdef RISCV_V_MUL_SEQ_RESULT_REG_EN
      wb_data_q    <= wb_data_d;
`endif
    end
  end

  assign req_ready_o     = (state_q == S_IDLE) && !flush_i;
  assign rf_rd_en_o      = (state_q == S_READ);
  assign rf_rd_idx_a_o   = vs1_q + k_ext;
  assign rf_rd_idx_b_o   = vs2_q + k_ext;
  assign mul_is_mul_o    = mul_is_mul_q;
  assign mul_is_high_o   = mul_hi_q;
  assign mul_is_signed_o = mul_sg_q;
  assign mul_osize_o     = mul_os_q;
  assign mul_srca_o      = srca_q;
  assign mul_srcb_o      = srcb_q;
  assign wb_valid_o      = (state_q == S_WB);
  assign wb_vd_o         = wb_vd_q;
  assign wb_last_o       = wb_last_q;
  assign busy_o          = (state_q != S_IDLE);
`ifdef RISCV_V_MUL_SEQ_RESULT_REG_EN
  assign wb_data_o       = wb_data_q;
`else
  // Operands and controls hold through WB, so the combinational product is stable there.
  assign wb_data_o       = wb_valid_o ? mul_result_i : '0;
`endif

endmodule

// File: tb/tb_riscv_v_mul_seq.sv
// Self-checking bench for riscv_v_mul_seq: behavioural multiplier and register file, directed plus random instructions.
module tb_riscv_v_mul_seq;
  localparam int DW = 128;
`ifdef RISCV_V_MUL_SEQ_RESULT_REG_EN
  localparam int CPC = 4;
`else
  localparam int CPC = 3;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic req_is_high = 1'b0, req_is_signed = 1'b0;
  logic [3:0] req_osize = 4'b0001;
  logic [3:0] req_num_chunks = 4'd1;
  logic [4:0] req_vs1 = '0, req_vs2 = '0, req_vd = '0;
  logic rf_rd_en;
  logic [4:0] rf_rd_idx_a, rf_rd_idx_b;
  logic [DW-1:0] rf_rdata_a = '0, rf_rdata_b = '0;
  logic mul_is_mul, mul_is_high, mul_is_signed;
  logic [3:0] mul_osize;
  logic [DW-1:0] mul_srca, mul_srcb, mul_result;
  logic wb_valid;
  logic wb_ready = 1'b1;
  logic [4:0] wb_vd;
  logic [DW-1:0] wb_data;
  logic wb_last, busy;

  logic [DW-1:0] rf [32];
  logic [DW-1:0] last_data;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_v_mul_seq dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_is_high_i(req_is_high), .req_is_signed_i(req_is_signed),
    .req_osize_i(req_osize), .req_num_chunks_i(req_num_chunks),
    .req_vs1_i(req_vs1), .req_vs2_i(req_vs2), .req_vd_i(req_vd),
    .rf_rd_en_o(rf_rd_en), .rf_rd_idx_a_o(rf_rd_idx_a), .rf_rd_idx_b_o(rf_rd_idx_b),
    .rf_rdata_a_i(rf_rdata_a), .rf_rdata_b_i(rf_rdata_b),
    .mul_is_mul_o(mul_is_mul), .mul_is_high_o(mul_is_high), .mul_is_signed_o(mul_is_signed),
    .mul_osize_o(mul_osize), .mul_srca_o(mul_srca), .mul_srcb_o(mul_srcb),
    .mul_result_i(mul_result),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_vd_o(wb_vd),
    .wb_data_o(wb_data), .wb_last_o(wb_last), .busy_o(busy)
  );

  // Elementwise product: sign/zero-extend each element, multiply, pick the requested half.
  function automatic logic [DW-1:0] mul_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [3:0] os, input logic hi, input logic sg);
    int ew;
    logic [127:0] x, y, p, r;
    r = '0;
    ew = os[0] ? 8 : os[1] ? 16 : os[2] ? 32 : 64;
    for (int e = 0; e < DW / ew; e++) begin
      x = '0;
      y = '0;
      for (int i = 0; i < ew; i++) begin
        x[i] = a[e*ew+i];
        y[i] = b[e*ew+i];
      end
      if (sg) begin
        for (int i = ew; i < 128; i++) begin
          x[i] = x[ew-1];
          y[i] = y[ew-1];
        end
      end
      p = x * y;
      for (int i = 0; i < ew; i++) r[e*ew+i] = hi ? p[ew+i] : p[i];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  assign mul_result = mul_is_mul ? mul_fn(mul_srca, mul_srcb, mul_osize, mul_is_high, mul_is_signed) : '0;

  // Register file: data valid the cycle after the strobe, garbage otherwise.
  always @(posedge clk) begin
    if (rf_rd_en) begin
      rf_rdata_a <= rf[rf_rd_idx_a];
      rf_rdata_b <= rf[rf_rd_idx_b];
    end else begin
      rf_rdata_a <= rand128();
      rf_rdata_b <= rand128();
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int n, input logic [4:0] vs1, input logic [4:0] vs2, input logic [4:0] vd,
                       input logic hi, input logic sg, input logic [3:0] os);
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_num_chunks = 4'(n);
    req_vs1 = vs1; req_vs2 = vs2; req_vd = vd;
    req_is_high = hi; req_is_signed = sg; req_osize = os;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic run_instr(input int n_req, input logic [4:0] vs1, input logic [4:0] vs2,
                           input logic [4:0] vd, input logic hi, input logic sg, input logic [3:0] os,
                           input int stall_chunk, input int stall_len);
    int n, cyc, chunk, read_cyc, stall_left, stall_total;
    bit seen_valid;
    logic [4:0] ia, ib, iv;
    logic [DW-1:0] exp_d;
    n = (n_req == 0) ? 1 : n_req;
    stall_total = (stall_chunk < n) ? stall_len : 0;
    issue(n_req, vs1, vs2, vd, hi, sg, os);
    cyc = 0; chunk = 0; read_cyc = 1; seen_valid = 0; stall_left = stall_len;
    wb_ready = 1'b1;
    while (chunk < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      ia = vs1 + 5'(chunk);
      ib = vs2 + 5'(chunk);
      iv = vd + 5'(chunk);
      if (rf_rd_en) begin
        chk("rd_cycle", cyc, read_cyc);
        chk("rd_idx_a", rf_rd_idx_a, ia);
        chk("rd_idx_b", rf_rd_idx_b, ib);
      end
      if (wb_valid) begin
        if (!seen_valid) begin
          chk("wb_valid_latency", cyc, read_cyc + CPC - 1);
          seen_valid = 1;
        end
        wb_ready = !(chunk == stall_chunk && stall_left > 0);
        if (!wb_ready) stall_left--;
        exp_d = mul_fn(rf[ia], rf[ib], os, hi, sg);
        chk("wb_data", wb_data, exp_d);
        chk("wb_vd", wb_vd, iv);
        chk("wb_last", wb_last, chunk == n - 1);
        chk("mul_is_mul", mul_is_mul, 1);
        chk("mul_ctrl", {mul_is_high, mul_is_signed, mul_osize}, {hi, sg, os});
        chk("mul_srca", mul_srca, rf[ia]);
        chk("mul_srcb", mul_srcb, rf[ib]);
        last_data = wb_data;
        if (wb_ready) begin
          if (chunk == n - 1) chk("total_cycles", cyc, CPC * n + stall_total);
          chunk++;
          read_cyc = cyc + 1;
          seen_valid = 0;
        end
      end
    end
    if (chunk < n) chk("instr_timeout", chunk, n);
    wb_ready = 1'b1;
    @(negedge clk);
    chk("post_req_ready", req_ready, 1);
    chk("post_idle", {busy, wb_valid, mul_is_mul}, 3'b000);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, cyc;
    for (int i = 0; i < 32; i++) rf[i] = rand128();

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_ctrl", {busy, wb_valid, rf_rd_en, mul_is_mul, wb_last}, 5'b0);
    chk("rst_srca", mul_srca, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_vd", wb_vd, 0);
    rst_n = 1'b1;

    // Single chunk, 8-bit unsigned low
    rf[2] = {16{8'hFF}};
    rf[3] = {16{8'h02}};
    run_instr(1, 5'd2, 5'd3, 5'd4, 1'b0, 1'b0, 4'b0001, 99, 0);
    chk("byte_fe", last_data, {16{8'hFE}});

    // LMUL=4 with index wrap
    run_instr(4, 5'd30, 5'd10, 5'd31, 1'b0, 1'b1, 4'b0010, 99, 0);

    // Signed high, 32-bit
    rf[5] = {4{32'hFFFFFFFE}};
    rf[6] = {4{32'h00000003}};
    run_instr(1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 4'b0100, 99, 0);
    chk("signed_high", last_data, {4{32'hFFFFFFFF}});

    // Backpressure on chunk 0 of 2
    run_instr(2, 5'd8, 5'd12, 5'd20, 1'b0, 1'b0, 4'b1000, 0, 5);

    // Zero-chunk request behaves as one chunk
    run_instr(0, 5'd1, 5'd9, 5'd17, 1'b1, 1'b0, 4'b1000, 99, 0);

    // Flush in OPND of chunk 1
    issue(2, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 4'b0001);
    cyc = 0;
    while (cyc < CPC + 2) begin
      @(negedge clk);
      cyc++;
    end
    chk("flush_pre_busy", {busy, rf_rd_en, wb_valid}, 3'b100);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_idle", {busy, mul_is_mul, wb_valid}, 3'b000);
    chk("flush_req_ready", req_ready, 1);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (wb_valid || rf_rd_en) cnt++;
    end
    chk("flush_quiet", cnt, 0);

    // Flush together with a request in IDLE
    flush = 1'b1;
    req_valid = 1'b1;
    #1 chk("flush_req_ready_low", req_ready, 0);
    @(posedge clk);
    #1 begin flush = 1'b0; req_valid = 1'b0; end
    @(negedge clk);
    chk("flush_req_dropped", busy, 0);

    // Async reset while stalled in WB
    issue(3, 5'd11, 5'd13, 5'd15, 1'b0, 1'b0, 4'b0100);
    wb_ready = 1'b0;
    cyc = 0;
    while (!wb_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_mid_wb_valid", wb_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid_drop", {wb_valid, busy, mul_is_mul}, 3'b000);
    chk("rst_mid_data", wb_data, 0);
    chk("rst_mid_req_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    wb_ready = 1'b1;

    // Random instructions
    for (int t = 0; t < 12; t++) begin
      run_instr($urandom_range(0, 8), 5'($urandom), 5'($urandom), 5'($urandom),
                1'($urandom), 1'($urandom), 4'(1 << $urandom_range(0, 3)),
                $urandom_range(0, 8), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/riscv_v_mul_seq.md
# riscv_v_mul_seq

Multi-cycle sequencer directly upstream of the vector multiplier datapath. Accepts one vector multiply instruction covering an LMUL register group, reads the two source chunks per register from the vector register file, and drives the multiplier's `is_mul`/`is_high`/`is_signed`/`osize_vector`/`srca`/`srcb` inputs from registers. It captures the multiplier result and presents it to write-back through a valid/ready handshake, one chunk per destination register.

## Interface
- `DATA_WIDTH`, default `RISCV_V_DATA_WIDTH` (128): chunk width; equals multiplier operand width.
- `MAX_CHUNKS`, default 8: maximum registers per group (LMUL=8).
- `REG_IDX_W`, default 5: vector register index width.
- `clk`  in  1: clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `flush`  in  1: synchronous abort; returns the block to IDLE.
- `req_valid`  in  1: instruction request valid.
- `req_ready`  out  1: block can accept a request.
- `req_is_high`, `req_is_signed`  in  1 each: select high or low product half; signed operands.
- `req_osize`  in  `osize_vector_t`: one-hot element size (8/16/32/64).
- `req_num_chunks`  in  4: registers in the group; legal values 1..MAX_CHUNKS; 0 is treated as 1.
- `req_vs1`, `req_vs2`, `req_vd`  in  REG_IDX_W each: base register indices.
- `rf_rd_en`  out  1: register-file read strobe.
- `rf_rd_idx_a`, `rf_rd_idx_b`  out  REG_IDX_W each: read indices.
- `rf_rdata_a`, `rf_rdata_b`  in  `riscv_v_alu_data_t`: read data, valid the cycle after `rf_rd_en`.
- `mul_is_mul`, `mul_is_high`, `mul_is_signed`  out  1 each: multiplier controls, registered.
- `mul_osize`  out  `osize_vector_t`: registered.
- `mul_srca`, `mul_srcb`  out  `riscv_v_alu_data_t`: registered operands.
- `mul_result`  in  `riscv_v_src_byte_vector_t`: combinational product from the multiplier.
- `wb_valid`  out  1: write-back data valid.
- `wb_ready`  in  1: write-back accepts.
- `wb_vd`  out  REG_IDX_W: destination register.
- `wb_data`  out  DATA_WIDTH: result chunk.
- `wb_last`  out  1: final chunk of the instruction.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- States: IDLE, READ, OPND, EXEC, WB.
- IDLE: `req_ready = !flush`.
  - A handshake latches the controls, the base indices and `num_chunks` (0→1), and clears chunk counter `k`.
  - Next state: READ.
- READ:
  - `rf_rd_en=1`, `rf_rd_idx_a = vs1+k`, `rf_rd_idx_b = vs2+k`. Additions are mod 2^REG_IDX_W, so indices wrap (31+1→0).
  - Next state: OPND.
- OPND:
  - Capture `rf_rdata_a`/`rf_rdata_b` into `mul_srca`/`mul_srcb`.
  - Set `mul_is_mul=1` and drive the latched high/signed/osize onto `mul_*`.
  - Next state: EXEC.
- EXEC: capture `mul_result` into the `wb_data` register. Set `wb_vd = vd+k` (wrapping) and `wb_last = (k == num_chunks-1)`. Next state: WB.
- WB:
  - `wb_valid=1`. `wb_data`, `wb_vd` and `wb_last` are held stable until `wb_ready`.
  - On handshake: if `wb_last`, go to IDLE and clear `mul_is_mul`; otherwise increment `k` and go to READ.
- `mul_is_mul` stays 1 from OPND through WB of each chunk. In IDLE it is 0, which gates `srca` inside the multiplier.
- `flush` in any state:
  - Next state is IDLE.
  - `wb_valid` drops the next cycle; no handshake completes in the flush cycle.
  - `mul_is_mul` is cleared; `k` is cleared.
- `flush` and `req_valid` in the same IDLE cycle: the request is not accepted.
- Reset values: all outputs 0 except `req_ready`, which is 1 after reset with `flush` low. State is IDLE, `k=0`, operand and result registers are 0.
- Reset asserted mid-instruction: immediate return to reset values; the partial group is dropped.

## Timing
- Per chunk, with `wb_ready` tied high: READ, OPND, EXEC, WB = 4 cycles. An N-chunk instruction therefore occupies N·4 cycles from the accept edge to the final WB handshake.
- First `wb_valid` rises 4 cycles after the `req_valid`&`req_ready` edge.
- `wb_ready` low stalls in WB indefinitely. No register-file read is issued while stalled.
- Back-to-back instructions: `req_ready` rises the cycle after the last WB handshake, so there is one idle cycle between instructions.
- The combinational path `mul_result`→register is limited to the multiplier's own depth. `mul_*` outputs come directly from flops.

## Configuration
- `RISCV_V_MUL_SEQ_RESULT_REG_EN` defined:
  - EXEC state is present and `wb_data` is a register, as described above.
  - 4 cycles per chunk.
- Not defined:
  - EXEC is removed; OPND goes directly to WB.
  - `wb_data = mul_result` combinationally. It is stable because the operand and control registers hold through WB.
  - 3 cycles per chunk; first `wb_valid` 3 cycles after accept.
  - `wb_vd` and `wb_last` are computed in OPND.

## Test plan
- **Single chunk, 8-bit unsigned low.**
  - Stimulus: 1 chunk, vs1=2, vs2=3, vd=4; all bytes A=0xFF, B=0x02; `wb_ready=1`.
  - Expected: `wb_valid` at cycle +4, `wb_vd=4`, every byte 0xFE, `wb_last=1`, `req_ready` high next cycle.
- **LMUL=4 with register wrap.**
  - Stimulus: vs1=30, vd=31, 4 chunks.
  - Expected: `rf_rd_idx_a` sequence 30,31,0,1; `wb_vd` sequence 31,0,1,2; `wb_last` only on the 4th chunk; total 16 cycles.
- **Signed high, 32-bit.**
  - Stimulus: A elements = -2 (0xFFFFFFFE), B elements = 3.
  - Expected: `mul_is_signed=1`, `mul_is_high=1`; `wb_data` elements 0xFFFFFFFF.
- **Write-back backpressure.**
  - Stimulus: hold `wb_ready=0` for 5 cycles during chunk 0 of 2.
  - Expected: `wb_data`/`wb_vd` stable, no `rf_rd_en` during the stall; chunk 1 READ the cycle after the handshake.
- **Flush, reset and zero-chunk request.**
  - Flush in OPND of chunk 1: IDLE next cycle, `mul_is_mul=0`, no `wb_valid`.
  - Async `rst_n` low mid-WB: `wb_valid` 0 immediately.
  - `req_num_chunks=0`: exactly one write-back with `wb_last=1`.
